// File: rtl/bram_access_arbiter.sv
// bram_access_arbiter: round-robin sequencer sharing one single-port BRAM between a FIFO drain writer and a random-address reader.
module bram_access_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_mem,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_gnt,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [DATA_WIDTH-1:0] bram_wdata,
    input  logic [DATA_WIDTH-1:0] bram_rdata,
    output logic [ADDR_WIDTH:0]   wr_count,
    output logic                  mem_full
);
    typedef enum logic [2:0] {IDLE, POP, WRITE, READ, RDATA} state_t;
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH:0]   wr_count_q, wr_count_d;
    logic                  prio_q, prio_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  wr_req, pick_wr, pick_rd;
    // prio_q: 0 favours the writer, 1 favours the reader on a tie
    always_comb begin
        wr_req     = !fifo_empty && !wr_count_q[ADDR_WIDTH];
        pick_wr    = state_q == IDLE && !clear && wr_req && (!rd_req || !prio_q);
        pick_rd    = state_q == IDLE && !clear && rd_req && !pick_wr;
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        wr_count_d = wr_count_q;
        rd_addr_d  = rd_addr_q;
        prio_d     = prio_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    wr_addr_d  = '0;
                    wr_count_d = '0;
                end else if (pick_wr) begin
                    state_d = POP;
                    prio_d  = 1'b1;
                end else if (pick_rd) begin
                    state_d   = READ;
                    rd_addr_d = rd_addr;
                    prio_d    = 1'b0;
                end
            end
            POP:   state_d = WRITE;
            WRITE: begin
                wr_addr_d  = wr_addr_q + 1'b1;
                wr_count_d = wr_count_q + 1'b1;
                state_d    = IDLE;
            end
            READ:  state_d = RDATA;
            RDATA: begin
                rd_data_d  = bram_rdata;
                rd_valid_d = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_mem or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            wr_addr_q  <= '0;
            wr_count_q <= '0;
            rd_addr_q  <= '0;
            prio_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            wr_count_q <= wr_count_d;
            rd_addr_q  <= rd_addr_d;
            prio_q     <= prio_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end
    // rd_gnt is gated so it stays low while reset holds the FSM in IDLE
    assign rd_gnt     = pick_rd && reset_n;
    assign fifo_rd_en = state_q == POP;
    assign bram_en    = state_q == WRITE || state_q == READ;
    assign bram_we    = state_q == WRITE;
    assign bram_addr  = state_q == WRITE ? wr_addr_q : state_q == READ ? rd_addr_q : '0;
    assign bram_wdata = state_q == WRITE ? fifo_rd_data : '0;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign wr_count   = wr_count_q;
    assign mem_full   = wr_count_q[ADDR_WIDTH];
endmodule

// File: tb/tb_bram_access_arbiter.sv
// tb_bram_access_arbiter: directed bench with FIFO and BRAM models around bram_access_arbiter.
module tb_bram_access_arbiter;
    logic       clk_mem = 1'b0;
    logic       reset_n = 1'b0;
    logic       clear = 1'b0;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] fifo_rd_data = 8'h00;
    logic       rd_req = 1'b0;
    logic [7:0] rd_addr = 8'h00;
    logic       rd_gnt;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       bram_en, bram_we;
    logic [7:0] bram_addr, bram_wdata;
    logic [7:0] bram_rdata = 8'h00;
    logic [8:0] wr_count;
    logic       mem_full;

    bram_access_arbiter #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) dut (
        .clk_mem(clk_mem), .reset_n(reset_n), .clear(clear), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_gnt(rd_gnt), .rd_data(rd_data), .rd_valid(rd_valid), .bram_en(bram_en),
        .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
        .bram_rdata(bram_rdata), .wr_count(wr_count), .mem_full(mem_full)
    );

    always #5 clk_mem = ~clk_mem;

    logic [7:0] mem [256];
    logic [7:0] fmem [512];
    int head = 0, tail = 0, base = 0;
    bit inf = 1'b0;
    assign fifo_empty = !inf && (head >= tail);

    // inf mode is a never-empty FIFO that yields 0,1,2,... from base
    always @(posedge clk_mem) begin
        if (bram_en && bram_we) mem[bram_addr] <= bram_wdata;
        if (bram_en && !bram_we) bram_rdata <= mem[bram_addr];
        if (fifo_rd_en) begin
            fifo_rd_data <= inf ? 8'(head - base) : fmem[head[8:0]];
            head <= head + 1;
        end
    end

    int cyc = 0, npop = 0, nval = 0, nen = 0, nev = 0;
    int pc [32];
    bit ev [64];
    always @(posedge clk_mem) cyc++;
    always @(negedge clk_mem) if (reset_n) begin
        if (fifo_rd_en) begin
            if (npop < 32) pc[npop] = cyc;
            npop++;
            if (nev < 64) ev[nev] = 1'b0;
            nev++;
        end
        if (rd_gnt) begin
            if (nev < 64) ev[nev] = 1'b1;
            nev++;
        end
        if (rd_valid) nval++;
        if (bram_en) nen++;
    end

    int checks = 0, errors = 0;
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_mem);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        rd_req = 1'b0;
        clear = 1'b0;
        inf = 1'b0;
        tail = head;
        repeat (2) @(negedge clk_mem);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] e);
        rd_req = 1'b1;
        rd_addr = a;
        #1;
        check("rd_gnt", rd_gnt, 1);
        tick();
        rd_req = 1'b0;
        #1;
        check("rd_gnt_pulse", rd_gnt, 0);
        check("rd_bram_en", {bram_en, bram_we}, 2'b10);
        check("rd_bram_addr", bram_addr, a);
        tick();
        check("rd_valid_early", rd_valid, 0);
        tick();
        check("rd_valid", rd_valid, 1);
        check("rd_data", rd_data, e);
        tick();
        check("rd_valid_pulse", rd_valid, 0);
        check("rd_data_held", rd_data, e);
    endtask

    initial begin
        int n0, bad;
        #1;
        check("reset_outs", {fifo_rd_en, rd_gnt, rd_valid, bram_en, bram_we, bram_addr, bram_wdata, rd_data, wr_count, mem_full}, 0);
        @(negedge clk_mem);
        reset_n = 1'b1;
        tick();
        n0 = nen;
        repeat (5) tick();
        check("idle_no_en", nen - n0, 0);

        for (int k = 0; k < 16; k++) fmem[(head + k) & 511] = 8'(k);
        n0 = npop;
        tail = head + 16;
        for (int i = 0; i < 100 && wr_count != 16; i++) tick();
        check("fill_count", wr_count, 16);
        check("fill_full", mem_full, 0);
        check("fill_pops", npop - n0, 16);
        bad = 0;
        for (int i = 1; i < 16; i++) if (pc[n0 + i] - pc[n0 + i - 1] != 3) bad++;
        check("pop_spacing", bad, 0);
        for (int k = 0; k < 16; k += 5) check("mem_k", mem[k], k);
        check("mem_15", mem[15], 15);
        tick();
        do_read(8'h05, 8'h05);
        do_read(8'h0F, 8'h0F);

        reset_n = 1'b0;
        #1;
        tail = head;
        base = head;
        inf = 1'b1;
        rd_req = 1'b1;
        rd_addr = 8'h10;
        nev = 0;
        @(negedge clk_mem);
        reset_n = 1'b1;
        for (int i = 0; i < 60 && nev < 8; i++) tick();
        check("rr_events", nev >= 8, 1);
        check("rr_first_w", ev[0], 0);
        bad = 0;
        for (int i = 1; i < 8; i++) if (ev[i] == ev[i - 1]) bad++;
        check("rr_alternate", bad, 0);

        do_reset();
        base = head;
        inf = 1'b1;
        for (int i = 0; i < 900 && !mem_full; i++) tick();
        tick();
        check("full_flag", mem_full, 1);
        check("full_count", wr_count, 256);
        check("full_mem0", mem[0], 8'h00);
        check("full_mem80", mem[8'h80], 8'h80);
        check("full_memff", mem[8'hFF], 8'hFF);
        n0 = npop;
        repeat (12) tick();
        check("full_no_pop", npop - n0, 0);
        do_read(8'h7F, 8'h7F);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_count", wr_count, 0);
        check("clear_full", mem_full, 0);
        for (int i = 0; i < 10 && !bram_we; i++) tick();
        check("clear_wr_we", bram_we, 1);
        check("clear_wr_addr", bram_addr, 0);

        do_reset();
        rd_req = 1'b1;
        rd_addr = 8'h03;
        #1;
        check("ab_rd_gnt", rd_gnt, 1);
        tick();
        rd_req = 1'b0;
        check("ab_rd_en", bram_en, 1);
        n0 = nval;
        #2 reset_n = 1'b0;
        #1;
        check("ab_rd_drop", {bram_en, bram_we, rd_gnt, rd_valid}, 0);
        @(negedge clk_mem);
        reset_n = 1'b1;
        repeat (6) tick();
        check("ab_rd_no_valid", nval - n0, 0);
        check("ab_rd_count", wr_count, 0);

        fmem[head & 511] = 8'h55;
        tail = head + 1;
        tick();
        check("ab_pop_en", fifo_rd_en, 1);
        #2 reset_n = 1'b0;
        #1;
        check("ab_pop_drop", {fifo_rd_en, bram_en}, 0);
        @(negedge clk_mem);
        reset_n = 1'b1;
        #1;
        check("ab_pop_count", wr_count, 0);
        check("ab_pop_no_valid", nval - n0, 0);
        tail = head;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bram_access_arbiter.md
Name: bram_access_arbiter

Overview:
- Memory-side sequencer in the clk_mem domain. It shares one single-port 256x8 BRAM between two requesters.
  - The write requester is the FIFO drain: pop the CDC FIFO, write the word to the next sequential address.
  - The read requester is a random-address read port.
- Alternates grants round-robin when both requesters want the BRAM in the same cycle, tracks the write fill level, and flags memory-full.
- Sits between the FIFO read side and the BRAM, replacing ad-hoc enable wiring in the memory controller.

Parameters:
- DATA_WIDTH, 8, BRAM/FIFO word width
- ADDR_WIDTH, 8, BRAM address width; depth = 2**ADDR_WIDTH

Ports:
- clk_mem  in  1  memory clock (65 MHz); single clock domain
- reset_n  in  1  asynchronous, active-low reset
- clear  in  1  sync request to zero write pointer/count; honoured only in IDLE
- fifo_empty  in  1  FIFO empty flag (clk_mem domain)
- fifo_rd_en  out  1  FIFO pop strobe; data returns next cycle
- fifo_rd_data  in  DATA_WIDTH  FIFO output word, valid cycle after fifo_rd_en
- rd_req  in  1  read request, level; held until rd_gnt
- rd_addr  in  ADDR_WIDTH  read address, sampled in rd_gnt cycle
- rd_gnt  out  1  one-cycle read accept pulse
- rd_data  out  DATA_WIDTH  read result, held until next read result
- rd_valid  out  1  one-cycle pulse, rd_data valid
- bram_en  out  1  BRAM enable
- bram_we  out  1  BRAM write enable
- bram_addr  out  ADDR_WIDTH  BRAM address
- bram_wdata  out  DATA_WIDTH  BRAM write data
- bram_rdata  in  DATA_WIDTH  BRAM read data, 1-cycle latency after bram_en & !bram_we
- wr_count  out  ADDR_WIDTH+1  words written since reset/clear (0..2**ADDR_WIDTH)
- mem_full  out  1  wr_count == 2**ADDR_WIDTH

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE, wr_addr=0, wr_count=0, prio=WRITE.
  - All outputs 0, including rd_data.
- Request conditions:
  - Write eligible: wr_req = !fifo_empty & !mem_full.
  - Read eligible: rd_req.
- FSM states:
  - IDLE:
    - clear=1 -> zero wr_addr/wr_count, stay IDLE, no grant this cycle.
    - Only wr_req -> POP.
    - Only rd_req -> rd_gnt=1 (combinational), latch rd_addr -> READ.
    - Both -> pick per prio; prio toggles to the other side after every grant of either kind.
  - POP: fifo_rd_en=1 for exactly this cycle -> WRITE.
  - WRITE:
    - bram_en=1, bram_we=1, bram_addr=wr_addr, bram_wdata=fifo_rd_data.
    - wr_addr+=1 (wraps mod 2**ADDR_WIDTH), wr_count+=1 -> IDLE.
  - READ: bram_en=1, bram_we=0, bram_addr=latched address -> RDATA.
  - RDATA: rd_data<=bram_rdata; rd_valid=1 in the next cycle (registered) -> IDLE.
- Outputs outside their states: bram_en, bram_we and fifo_rd_en are 0 in all other states.
- Timing:
  - Write: 3 cycles per word (IDLE, POP, WRITE); back-to-back writes give fifo_rd_en every 3rd cycle.
  - Read: rd_valid asserts exactly 3 cycles after the rd_gnt cycle; next grant possible in that same cycle.
- Boundaries:
  - fifo_empty rising while in POP/WRITE does not abort; the pop already issued completes.
  - mem_full: no further pops; reads still served; wr_addr is 0 after 2**ADDR_WIDTH writes.
  - clear while busy: ignored until IDLE; clear is not latched.
  - Reads of unwritten addresses are legal and return raw BRAM contents.
- Reset mid-operation:
  - Immediate return to IDLE with all strobes low.
  - A word popped in POP/WRITE is lost (documented, not an error).
  - An aborted read produces no rd_valid.
- No combinational path from bram_rdata to any output.

Test Plan:
- Reset asserted mid-clock -> all outputs 0 immediately; after release, idle with fifo_empty=1 -> bram_en stays 0.
- FIFO preloaded 0x00..0x0F, rd_req=0 -> 16 fifo_rd_en pulses spaced 3 cycles; BRAM addr k holds k for k=0..15; wr_count=16, mem_full=0.
- After previous, rd_req with rd_addr=0x05 -> rd_gnt one cycle; rd_valid 3 cycles later with rd_data=0x05; a second read of 0x0F returns 0x0F.
- fifo_empty=0 and rd_req=1 held continuously from reset -> grant order W,R,W,R...; first grant is write; no two consecutive same-side grants.
- 256 writes of i&8'hFF -> mem_full=1, wr_count=256, fifo_rd_en stays 0 with fifo_empty=0; reads still complete; clear in IDLE -> wr_count=0, mem_full=0, next write to addr 0.
- reset_n pulsed low during READ and, separately, during POP -> rd_valid never pulses; bram_en/fifo_rd_en drop same instant; wr_count unchanged from 0 after reset.
